// File: rtl/tl_sbus_edge_buffer_if.sv
// TileLink-UL A/D channel bundle between the width-widget coupler and the slave port.
// master drives A and consumes D; slave consumes A and drives D.
interface tl_sbus_edge_buffer_if;
    // Handshake: a beat transfers on a rising clock edge where valid && ready are both 1.
    // Once valid rises it stays high with stable bits until that transfer happens, and
    // valid never waits on ready.
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_bits_opcode;
    logic [2:0]  a_bits_param;
    logic [3:0]  a_bits_size;
    logic        a_bits_source;
    logic [31:0] a_bits_address;
    logic [7:0]  a_bits_mask;
    logic [63:0] a_bits_data;
    logic        a_bits_corrupt;

    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_bits_opcode;
    logic [1:0]  d_bits_param;
    logic [3:0]  d_bits_size;
    logic        d_bits_source;
    logic [1:0]  d_bits_sink;
    logic        d_bits_denied;
    logic [63:0] d_bits_data;
    logic        d_bits_corrupt;

    modport master (
        input  a_ready,
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
        output d_ready,
        input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
    );

    modport slave (
        output a_ready,
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
        input  d_ready,
        output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
    );
endinterface

// File: rtl/tl_sbus_edge_buffer.sv
// Decoupling buffer on the bus-crossing path: one independent circular FIFO per TileLink
// channel (A in->out, D out->in), so no ready/valid path crosses the block combinationally.

module tl_sbus_edge_buffer_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             enq_fire;
    logic             deq_fire;

    // Flags come from the registered count only; a full FIFO refuses a beat even
    // when a dequeue happens in the same cycle.
    assign enq_ready = (count != FULL);
    assign deq_valid = (count != '0);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;
    assign deq_bits  = mem[rptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
            end
            if (deq_fire) begin
                rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            mem[wptr] <= enq_bits;
        end
    end
endmodule

module tl_sbus_edge_buffer #(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    tl_sbus_edge_buffer_if.slave  auto_in,
    tl_sbus_edge_buffer_if.master auto_out
);
    localparam int A_W = 116;
    localparam int D_W = 78;

    logic [A_W-1:0] a_enq_bits;
    logic [A_W-1:0] a_deq_bits;
    logic [D_W-1:0] d_enq_bits;
    logic [D_W-1:0] d_deq_bits;

    // Fields are carried as one flat word; packing and unpacking use the same order.
    assign a_enq_bits = {auto_in.a_bits_opcode, auto_in.a_bits_param, auto_in.a_bits_size,
                         auto_in.a_bits_source, auto_in.a_bits_address, auto_in.a_bits_mask,
                         auto_in.a_bits_data, auto_in.a_bits_corrupt};

    assign {auto_out.a_bits_opcode, auto_out.a_bits_param, auto_out.a_bits_size,
            auto_out.a_bits_source, auto_out.a_bits_address, auto_out.a_bits_mask,
            auto_out.a_bits_data, auto_out.a_bits_corrupt} = a_deq_bits;

    assign d_enq_bits = {auto_out.d_bits_opcode, auto_out.d_bits_param, auto_out.d_bits_size,
                         auto_out.d_bits_source, auto_out.d_bits_sink, auto_out.d_bits_denied,
                         auto_out.d_bits_data, auto_out.d_bits_corrupt};

    assign {auto_in.d_bits_opcode, auto_in.d_bits_param, auto_in.d_bits_size,
            auto_in.d_bits_source, auto_in.d_bits_sink, auto_in.d_bits_denied,
            auto_in.d_bits_data, auto_in.d_bits_corrupt} = d_deq_bits;

    tl_sbus_edge_buffer_fifo #(
        .WIDTH (A_W),
        .DEPTH (A_DEPTH)
    ) a_fifo (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_in.a_valid),
        .enq_ready (auto_in.a_ready),
        .enq_bits  (a_enq_bits),
        .deq_valid (auto_out.a_valid),
        .deq_ready (auto_out.a_ready),
        .deq_bits  (a_deq_bits)
    );

    // Responses flow the other way: the slave side fills, the coupler side drains.
    tl_sbus_edge_buffer_fifo #(
        .WIDTH (D_W),
        .DEPTH (D_DEPTH)
    ) d_fifo (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_out.d_valid),
        .enq_ready (auto_out.d_ready),
        .enq_bits  (d_enq_bits),
        .deq_valid (auto_in.d_valid),
        .deq_ready (auto_in.d_ready),
        .deq_bits  (d_deq_bits)
    );
endmodule

// File: tb/tb_tl_sbus_edge_buffer.sv
// Directed bench for tl_sbus_edge_buffer: a 2/2 build for most scenarios and a 1/3 build
// for the single-entry A throughput and deeper D buffering cases.
module tb_tl_sbus_edge_buffer;
    localparam int AW = 116;
    localparam int DW = 78;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [AW-1:0] a_exp_q[$];
    logic [DW-1:0] d_exp_q[$];

    tl_sbus_edge_buffer_if in_if ();
    tl_sbus_edge_buffer_if out_if ();
    tl_sbus_edge_buffer_if in1_if ();
    tl_sbus_edge_buffer_if out1_if ();

    tl_sbus_edge_buffer #(.A_DEPTH(2), .D_DEPTH(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .auto_in  (in_if),
        .auto_out (out_if)
    );

    tl_sbus_edge_buffer #(.A_DEPTH(1), .D_DEPTH(3)) dut1 (
        .clock    (clock),
        .reset    (reset),
        .auto_in  (in1_if),
        .auto_out (out1_if)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    // beat builders: opcode alternates PutFull/PutPartial, address/data/mask track index
    function automatic logic [AW-1:0] mk_a(input int i);
        logic [31:0] u;
        u = i;
        return {(u[0] ? 3'd1 : 3'd0), 3'd0, 4'd3, u[1], 32'h8000_0000 + (u << 3),
                8'hff - u[7:0], 64'h1122_3344_5566_7788 + {32'h0, u}, u[2]};
    endfunction

    // AccessAckData, source=1, sink=2, denied=0, corrupt=1
    function automatic logic [DW-1:0] mk_d(input int i);
        logic [31:0] u;
        u = i;
        return {3'd1, 2'd0, 4'd3, 1'b1, 2'd2, 1'b0, 64'hA5A5_0000_0000_0000 + {32'h0, u}, 1'b1};
    endfunction

    function automatic logic [AW-1:0] out_a_bits();
        return {out_if.a_bits_opcode, out_if.a_bits_param, out_if.a_bits_size, out_if.a_bits_source,
                out_if.a_bits_address, out_if.a_bits_mask, out_if.a_bits_data, out_if.a_bits_corrupt};
    endfunction

    function automatic logic [AW-1:0] out1_a_bits();
        return {out1_if.a_bits_opcode, out1_if.a_bits_param, out1_if.a_bits_size, out1_if.a_bits_source,
                out1_if.a_bits_address, out1_if.a_bits_mask, out1_if.a_bits_data, out1_if.a_bits_corrupt};
    endfunction

    function automatic logic [DW-1:0] in_d_bits();
        return {in_if.d_bits_opcode, in_if.d_bits_param, in_if.d_bits_size, in_if.d_bits_source,
                in_if.d_bits_sink, in_if.d_bits_denied, in_if.d_bits_data, in_if.d_bits_corrupt};
    endfunction

    function automatic logic [DW-1:0] in1_d_bits();
        return {in1_if.d_bits_opcode, in1_if.d_bits_param, in1_if.d_bits_size, in1_if.d_bits_source,
                in1_if.d_bits_sink, in1_if.d_bits_denied, in1_if.d_bits_data, in1_if.d_bits_corrupt};
    endfunction

    // driver tasks
    task automatic drive_a(input logic v, input logic [AW-1:0] b);
        in_if.a_valid = v;
        {in_if.a_bits_opcode, in_if.a_bits_param, in_if.a_bits_size, in_if.a_bits_source,
         in_if.a_bits_address, in_if.a_bits_mask, in_if.a_bits_data, in_if.a_bits_corrupt} = b;
    endtask

    task automatic drive_a1(input logic v, input logic [AW-1:0] b);
        in1_if.a_valid = v;
        {in1_if.a_bits_opcode, in1_if.a_bits_param, in1_if.a_bits_size, in1_if.a_bits_source,
         in1_if.a_bits_address, in1_if.a_bits_mask, in1_if.a_bits_data, in1_if.a_bits_corrupt} = b;
    endtask

    task automatic drive_d(input logic v, input logic [DW-1:0] b);
        out_if.d_valid = v;
        {out_if.d_bits_opcode, out_if.d_bits_param, out_if.d_bits_size, out_if.d_bits_source,
         out_if.d_bits_sink, out_if.d_bits_denied, out_if.d_bits_data, out_if.d_bits_corrupt} = b;
    endtask

    task automatic drive_d1(input logic v, input logic [DW-1:0] b);
        out1_if.d_valid = v;
        {out1_if.d_bits_opcode, out1_if.d_bits_param, out1_if.d_bits_size, out1_if.d_bits_source,
         out1_if.d_bits_sink, out1_if.d_bits_denied, out1_if.d_bits_data, out1_if.d_bits_corrupt} = b;
    endtask

    task automatic test_reset();
        logic [AW-1:0] nb;
        @(negedge clock);
        checks++; if (in_if.a_ready !== 1'b1) begin errors++; $display("FAIL rst_in_a_ready: got %b expected 1", in_if.a_ready); end
        checks++; if (out_if.a_valid !== 1'b0) begin errors++; $display("FAIL rst_out_a_valid: got %b expected 0", out_if.a_valid); end
        checks++; if (in_if.d_valid !== 1'b0) begin errors++; $display("FAIL rst_in_d_valid: got %b expected 0", in_if.d_valid); end
        checks++; if (out_if.d_ready !== 1'b1) begin errors++; $display("FAIL rst_out_d_ready: got %b expected 1", out_if.d_ready); end
        checks++; if (in1_if.a_ready !== 1'b1) begin errors++; $display("FAIL rst1_in_a_ready: got %b expected 1", in1_if.a_ready); end
        checks++; if (out1_if.a_valid !== 1'b0) begin errors++; $display("FAIL rst1_out_a_valid: got %b expected 0", out1_if.a_valid); end
        reset = 1'b1;
        out_if.a_ready = 1'b0;
        drive_a(1'b1, mk_a(300));
        @(negedge clock);
        drive_a(1'b1, mk_a(301));
        @(negedge clock);
        drive_a(1'b0, '0);
        checks++; if (out_if.a_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", out_if.a_valid); end
        checks++; if (in_if.a_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_full: got %b expected 0", in_if.a_ready); end
        // asynchronous assertion between clock edges
        #2 reset = 1'b0;
        #1;
        checks++; if (out_if.a_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", out_if.a_valid); end
        checks++; if (in_if.a_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", in_if.a_ready); end
        checks++; if (in_if.d_valid !== 1'b0) begin errors++; $display("FAIL rst_async_d_valid: got %b expected 0", in_if.d_valid); end
        checks++; if (out_if.d_ready !== 1'b1) begin errors++; $display("FAIL rst_async_d_ready: got %b expected 1", out_if.d_ready); end
        @(negedge clock);
        reset = 1'b1;
        out_if.a_ready = 1'b1;
        nb = mk_a(310);
        drive_a(1'b1, nb);
        @(negedge clock);
        drive_a(1'b0, '0);
        checks++; if (out_if.a_valid !== 1'b1) begin errors++; $display("FAIL rst_post_valid: got %b expected 1", out_if.a_valid); end
        checks++; if (out_a_bits() !== nb) begin errors++; $display("FAIL rst_post_bits: got %h expected %h", out_a_bits(), nb); end
        @(negedge clock);
        checks++; if (out_if.a_valid !== 1'b0) begin errors++; $display("FAIL rst_post_empty: got %b expected 0", out_if.a_valid); end
    endtask

    task automatic test_latency();
        logic [AW-1:0] b;
        b = mk_a(0);
        out_if.a_ready = 1'b1;
        drive_a(1'b1, b);
        checks++; if (out_if.a_valid !== 1'b0) begin errors++; $display("FAIL lat_no_flow: got %b expected 0", out_if.a_valid); end
        @(negedge clock);
        drive_a(1'b0, '0);
        checks++; if (out_if.a_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", out_if.a_valid); end
        checks++; if (out_a_bits() !== b) begin errors++; $display("FAIL lat_bits: got %h expected %h", out_a_bits(), b); end
        checks++; if (out_if.a_bits_address !== 32'h8000_0000) begin errors++; $display("FAIL lat_addr: got %h expected 80000000", out_if.a_bits_address); end
        checks++; if (out_if.a_bits_data !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL lat_data: got %h expected 1122334455667788", out_if.a_bits_data); end
        checks++; if (out_if.a_bits_opcode !== 3'd0) begin errors++; $display("FAIL lat_opcode: got %0d expected 0", out_if.a_bits_opcode); end
        @(negedge clock);
        checks++; if (out_if.a_valid !== 1'b0) begin errors++; $display("FAIL lat_drained: got %b expected 0", out_if.a_valid); end
    endtask

    task automatic test_back_to_back();
        int got;
        got = 0;
        a_exp_q.delete();
        out_if.a_ready = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            checks++; if (out_if.a_valid !== 1'(cyc >= 1)) begin errors++; $display("FAIL b2b_valid c%0d: got %b expected %b", cyc, out_if.a_valid, cyc >= 1); end
            checks++; if (in_if.a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d: got %b expected 1", cyc, in_if.a_ready); end
            if (out_if.a_valid === 1'b1) begin
                checks++;
                if (a_exp_q.size() == 0 || out_a_bits() !== a_exp_q[0]) begin
                    errors++; $display("FAIL b2b_order c%0d: got %h expected %h", cyc, out_a_bits(), (a_exp_q.size() != 0) ? a_exp_q[0] : '0);
                end
                if (a_exp_q.size() != 0) void'(a_exp_q.pop_front());
                got++;
            end
            if (cyc < 8) begin
                drive_a(1'b1, mk_a(10 + cyc));
                a_exp_q.push_back(mk_a(10 + cyc));
            end else begin
                drive_a(1'b0, '0);
            end
            @(negedge clock);
        end
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
        checks++; if (out_if.a_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_if.a_valid); end
    endtask

    task automatic test_full();
        out_if.a_ready = 1'b0;
        drive_a(1'b1, mk_a(21));
        @(negedge clock);
        checks++; if (in_if.a_ready !== 1'b1) begin errors++; $display("FAIL full_one: got %b expected 1", in_if.a_ready); end
        drive_a(1'b1, mk_a(22));
        @(negedge clock);
        checks++; if (in_if.a_ready !== 1'b0) begin errors++; $display("FAIL full_two: got %b expected 0", in_if.a_ready); end
        checks++; if (out_a_bits() !== mk_a(21)) begin errors++; $display("FAIL full_head: got %h expected %h", out_a_bits(), mk_a(21)); end
        drive_a(1'b1, mk_a(23));
        @(negedge clock);
        checks++; if (in_if.a_ready !== 1'b0) begin errors++; $display("FAIL full_hold: got %b expected 0", in_if.a_ready); end
        checks++; if (out_if.a_valid !== 1'b1 || out_a_bits() !== mk_a(21)) begin errors++; $display("FAIL full_stable: got %h expected %h", out_a_bits(), mk_a(21)); end
        out_if.a_ready = 1'b1;
        @(negedge clock);
        // full at the deq edge, so beat 3 was refused and exactly one entry remains
        checks++; if (in_if.a_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b expected 1", in_if.a_ready); end
        checks++; if (out_a_bits() !== mk_a(22)) begin errors++; $display("FAIL full_second: got %h expected %h", out_a_bits(), mk_a(22)); end
        @(negedge clock);
        drive_a(1'b0, '0);
        checks++; if (out_if.a_valid !== 1'b1 || out_a_bits() !== mk_a(23)) begin errors++; $display("FAIL full_third: got %h expected %h", out_a_bits(), mk_a(23)); end
        @(negedge clock);
        checks++; if (out_if.a_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", out_if.a_valid); end
    endtask

    task automatic test_simultaneous();
        out_if.a_ready = 1'b0;
        drive_a(1'b1, mk_a(30));
        @(negedge clock);
        out_if.a_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            checks++; if (in_if.a_ready !== 1'b1 || out_if.a_valid !== 1'b1) begin errors++; $display("FAIL sim_count k%0d: got ready=%b valid=%b expected 1 1", k, in_if.a_ready, out_if.a_valid); end
            checks++; if (out_a_bits() !== mk_a(30 + k - 1)) begin errors++; $display("FAIL sim_data k%0d: got %h expected %h", k, out_a_bits(), mk_a(30 + k - 1)); end
            if (k < 6) drive_a(1'b1, mk_a(30 + k));
            else drive_a(1'b0, '0);
            @(negedge clock);
        end
        checks++; if (out_if.a_valid !== 1'b0) begin errors++; $display("FAIL sim_empty: got %b expected 0", out_if.a_valid); end
    endtask

    task automatic test_d_path();
        logic [DW-1:0] held;
        logic stalled;
        int sent;
        int got;
        int cyc;
        stalled = 1'b0;
        held = '0;
        sent = 0;
        got = 0;
        cyc = 0;
        d_exp_q.delete();
        while (got < 4 && cyc < 60) begin
            if (stalled) begin
                checks++; if (in_if.d_valid !== 1'b1 || in_d_bits() !== held) begin errors++; $display("FAIL d_stable c%0d: got %b/%h expected 1/%h", cyc, in_if.d_valid, in_d_bits(), held); end
            end
            if (cyc == 2) begin
                checks++; if (out_if.d_ready !== 1'b0) begin errors++; $display("FAIL d_full: got %b expected 0", out_if.d_ready); end
            end
            in_if.d_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
            stalled = 1'b0;
            if (in_if.d_valid === 1'b1) begin
                if (in_if.d_ready) begin
                    checks++;
                    if (d_exp_q.size() == 0 || in_d_bits() !== d_exp_q[0]) begin
                        errors++; $display("FAIL d_order c%0d: got %h expected %h", cyc, in_d_bits(), (d_exp_q.size() != 0) ? d_exp_q[0] : '0);
                    end
                    if (d_exp_q.size() != 0) void'(d_exp_q.pop_front());
                    got++;
                end else begin
                    stalled = 1'b1;
                    held = in_d_bits();
                end
            end
            if (sent < 4) begin
                drive_d(1'b1, mk_d(sent));
                if (out_if.d_ready === 1'b1) begin
                    d_exp_q.push_back(mk_d(sent));
                    sent++;
                end
            end else begin
                drive_d(1'b0, '0);
            end
            @(negedge clock);
            cyc++;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL d_timeout: got %0d beats expected 4", got); end
        drive_d(1'b0, '0);
        in_if.d_ready = 1'b1;
    endtask

    task automatic test_depth1();
        int sent;
        int got;
        sent = 0;
        got = 0;
        a_exp_q.delete();
        out1_if.a_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            checks++; if (in1_if.a_ready !== 1'(cyc % 2 == 0)) begin errors++; $display("FAIL d1a_ready c%0d: got %b expected %b", cyc, in1_if.a_ready, cyc % 2 == 0); end
            checks++; if (out1_if.a_valid !== 1'(cyc % 2 == 1)) begin errors++; $display("FAIL d1a_valid c%0d: got %b expected %b", cyc, out1_if.a_valid, cyc % 2 == 1); end
            if (out1_if.a_valid === 1'b1) begin
                checks++;
                if (a_exp_q.size() == 0 || out1_a_bits() !== a_exp_q[0]) begin
                    errors++; $display("FAIL d1a_order c%0d: got %h expected %h", cyc, out1_a_bits(), (a_exp_q.size() != 0) ? a_exp_q[0] : '0);
                end
                if (a_exp_q.size() != 0) void'(a_exp_q.pop_front());
                got++;
            end
            if (sent < 8) begin
                drive_a1(1'b1, mk_a(400 + sent));
                if (in1_if.a_ready === 1'b1) begin
                    a_exp_q.push_back(mk_a(400 + sent));
                    sent++;
                end
            end else begin
                drive_a1(1'b0, '0);
            end
            @(negedge clock);
        end
        checks++; if (got != 8) begin errors++; $display("FAIL d1a_count: got %0d expected 8", got); end
        checks++; if (out1_if.a_valid !== 1'b0) begin errors++; $display("FAIL d1a_empty: got %b expected 0", out1_if.a_valid); end

        in1_if.d_ready = 1'b0;
        d_exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            checks++; if (out1_if.d_ready !== 1'b1) begin errors++; $display("FAIL d1d_accept k%0d: got %b expected 1", k, out1_if.d_ready); end
            drive_d1(1'b1, mk_d(50 + k));
            d_exp_q.push_back(mk_d(50 + k));
            @(negedge clock);
        end
        drive_d1(1'b0, '0);
        checks++; if (out1_if.d_ready !== 1'b0) begin errors++; $display("FAIL d1d_full: got %b expected 0", out1_if.d_ready); end
        in1_if.d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in1_if.d_valid !== 1'b1 || d_exp_q.size() == 0 || in1_d_bits() !== d_exp_q[0]) begin
                errors++; $display("FAIL d1d_order k%0d: got %b/%h expected 1/%h", k, in1_if.d_valid, in1_d_bits(), (d_exp_q.size() != 0) ? d_exp_q[0] : '0);
            end
            if (d_exp_q.size() != 0) void'(d_exp_q.pop_front());
            @(negedge clock);
        end
        checks++; if (in1_if.d_valid !== 1'b0) begin errors++; $display("FAIL d1d_empty: got %b expected 0", in1_if.d_valid); end
    endtask

    initial begin
        reset = 1'b0;
        drive_a(1'b0, '0);
        drive_a1(1'b0, '0);
        drive_d(1'b0, '0);
        drive_d1(1'b0, '0);
        out_if.a_ready  = 1'b1;
        in_if.d_ready   = 1'b1;
        out1_if.a_ready = 1'b1;
        in1_if.d_ready  = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_full();
        test_simultaneous();
        test_d_path();
        test_depth1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
